// File: rtl/cook_sequencer.sv
// Microwave cook controller: sequences keypad entry, countdown ticks, pause/resume
// and the end-of-cook beep for the BCD down-timer, all synchronous to clk.
module cook_sequencer #(
    parameter int TICK_DIV   = 100,
    parameter int MAX_DIGITS = 3,
    parameter int BEEP_TICKS = 3
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start_n,
    input  logic       stop_n,
    input  logic       clear_n,
    input  logic       door_closed,
    input  logic       timer_zero,
    output logic       load_n,
    output logic [3:0] load_data,
    output logic       timer_clr_n,
    output logic       count_en,
    output logic       mag_on,
    output logic       beep,
    output logic [2:0] state
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(MAX_DIGITS + 1);
    localparam int BW = $clog2(BEEP_TICKS + 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ENTRY = 3'd1;
    localparam logic [2:0] COOK  = 3'd2;
    localparam logic [2:0] PAUSE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [PW-1:0] prescaler;
    logic [DW-1:0] digit_cnt;
    logic [BW-1:0] beep_cnt;
    logic          start_q;
    logic          stop_q;
    logic          clear_q;

    logic start_ev;
    logic stop_ev;
    logic clear_ev;
    logic key_ok;
    logic wrap;

    // A press is a released-to-pressed transition, so a held button fires once
    assign start_ev = start_q & ~start_n;
    assign stop_ev  = stop_q & ~stop_n;
    assign clear_ev = clear_q & ~clear_n;
    assign key_ok   = key_valid && (key_digit <= 4'd9);
    assign wrap     = (prescaler == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state       <= IDLE;
            load_n      <= 1'b1;
            load_data   <= 4'd0;
            timer_clr_n <= 1'b1;
            count_en    <= 1'b0;
            beep        <= 1'b0;
            digit_cnt   <= '0;
            prescaler   <= '0;
            beep_cnt    <= '0;
            start_q     <= 1'b1;
            stop_q      <= 1'b1;
            clear_q     <= 1'b1;
        end else begin
            start_q     <= start_n;
            stop_q      <= stop_n;
            clear_q     <= clear_n;
            load_n      <= 1'b1;
            timer_clr_n <= 1'b1;
            count_en    <= 1'b0;

            case (state)
                IDLE: begin
                    if (clear_ev) begin
                        timer_clr_n <= 1'b0;
                    end else if (!stop_ev) begin
                        if (start_ev) begin
                            if (door_closed && !timer_zero) begin
                                state     <= COOK;
                                prescaler <= '0;
                            end
                        end else if (key_ok) begin
                            load_n    <= 1'b0;
                            load_data <= key_digit;
                            digit_cnt <= DW'(1);
                            state     <= ENTRY;
                        end
                    end
                end
                ENTRY: begin
                    if (clear_ev || stop_ev) begin
                        timer_clr_n <= 1'b0;
                        digit_cnt   <= '0;
                        state       <= IDLE;
                    end else if (start_ev) begin
                        if (door_closed && !timer_zero) begin
                            state     <= COOK;
                            prescaler <= '0;
                            digit_cnt <= '0;
                        end
                    end else if (key_ok && (digit_cnt < DW'(MAX_DIGITS))) begin
                        load_n    <= 1'b0;
                        load_data <= key_digit;
                        digit_cnt <= digit_cnt + 1'b1;
                    end
                end
                COOK: begin
                    // A zero seen while a decrement is in flight is stale, so wait it out
                    if (clear_ev) begin
                        timer_clr_n <= 1'b0;
                        state       <= IDLE;
                    end else if (stop_ev || !door_closed) begin
                        state <= PAUSE;
                    end else if (timer_zero && !count_en) begin
                        state     <= DONE;
                        beep      <= 1'b1;
                        beep_cnt  <= '0;
                        prescaler <= '0;
                    end else if (wrap) begin
                        prescaler <= '0;
                        count_en  <= 1'b1;
                    end else begin
                        prescaler <= prescaler + 1'b1;
                    end
                end
                PAUSE: begin
                    if (clear_ev || stop_ev) begin
                        timer_clr_n <= 1'b0;
                        state       <= IDLE;
                    end else if (start_ev && door_closed) begin
                        state <= COOK;
                    end
                end
                DONE: begin
                    if (clear_ev || stop_ev || key_ok) begin
                        state <= IDLE;
                        beep  <= 1'b0;
                    end else if (wrap) begin
                        prescaler <= '0;
                        beep_cnt  <= beep_cnt + 1'b1;
                        if ((beep_cnt + 1'b1) == BW'(BEEP_TICKS)) begin
                            state <= IDLE;
                            beep  <= 1'b0;
                        end
                    end else begin
                        prescaler <= prescaler + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    beep  <= 1'b0;
                end
            endcase
        end
    end

    // The door gate stays combinational so the magnetron drops before the FSM reacts
    assign mag_on = (state == COOK) && door_closed;

endmodule

// File: tb/tb_cook_sequencer.sv
// Randomised scoreboard bench for cook_sequencer: a behavioural model predicts
// strobes and levels per cycle, and a monitor process checks the DUT against them.
module tb_cook_sequencer;

    localparam int TICK_DIV   = 4;
    localparam int MAX_DIGITS = 3;
    localparam int BEEP_TICKS = 3;

    localparam int S_IDLE  = 0;
    localparam int S_ENTRY = 1;
    localparam int S_COOK  = 2;
    localparam int S_PAUSE = 3;
    localparam int S_DONE  = 4;

    localparam int EV_LOAD = 1;
    localparam int EV_CLR  = 2;
    localparam int EV_CNT  = 4;

    typedef struct {
        int kind;
        int cyc;
        int data;
    } ev_t;

    typedef struct {
        int st;
        int bp;
        int mag;
    } snap_t;

    logic       clk;
    logic       clrn;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       start_n;
    logic       stop_n;
    logic       clear_n;
    logic       door_closed;
    logic       timer_zero;
    logic       load_n;
    logic [3:0] load_data;
    logic       timer_clr_n;
    logic       count_en;
    logic       mag_on;
    logic       beep;
    logic [2:0] state;

    int tests;
    int fails;
    int scyc;
    int mcyc;
    bit mon_en;

    ev_t   ev_q[$];
    snap_t exp_q[$];

    // Reference model: mode plus elapsed-cycle counters for cooking and beeping
    int m_mode;
    int m_digits;
    int m_cook_cycles;
    int m_done_cycles;
    int m_cnt;
    bit m_start_q;
    bit m_stop_q;
    bit m_clear_q;

    cook_sequencer #(
        .TICK_DIV  (TICK_DIV),
        .MAX_DIGITS(MAX_DIGITS),
        .BEEP_TICKS(BEEP_TICKS)
    ) dut (
        .clk        (clk),
        .clrn       (clrn),
        .key_valid  (key_valid),
        .key_digit  (key_digit),
        .start_n    (start_n),
        .stop_n     (stop_n),
        .clear_n    (clear_n),
        .door_closed(door_closed),
        .timer_zero (timer_zero),
        .load_n     (load_n),
        .load_data  (load_data),
        .timer_clr_n(timer_clr_n),
        .count_en   (count_en),
        .mag_on     (mag_on),
        .beep       (beep),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d, t=%0t)",
                     name, actual, expected, mcyc, $time);
        end
    endtask

    task automatic modelReset();
        m_mode        = S_IDLE;
        m_digits      = 0;
        m_cook_cycles = 0;
        m_done_cycles = 0;
        m_cnt         = 0;
        m_start_q     = 1'b1;
        m_stop_q      = 1'b1;
        m_clear_q     = 1'b1;
    endtask

    task automatic pushEv(input int kind, input int data);
        ev_q.push_back('{kind, scyc, data});
    endtask

    // Called at a falling edge with inputs already driven; predicts the next rising edge
    task automatic applyStimulus();
        bit st_ev, sp_ev, cl_ev, key_ok;
        int cnt_now;
        st_ev   = m_start_q && !start_n;
        sp_ev   = m_stop_q && !stop_n;
        cl_ev   = m_clear_q && !clear_n;
        key_ok  = key_valid && (int'(key_digit) <= 9);
        m_start_q = start_n;
        m_stop_q  = stop_n;
        m_clear_q = clear_n;
        cnt_now = 0;
        case (m_mode)
            S_IDLE: begin
                if (cl_ev) pushEv(EV_CLR, 0);
                else if (!sp_ev) begin
                    if (st_ev) begin
                        if (door_closed && !timer_zero) begin
                            m_mode = S_COOK;
                            m_cook_cycles = 0;
                        end
                    end else if (key_ok) begin
                        pushEv(EV_LOAD, int'(key_digit));
                        m_digits = 1;
                        m_mode = S_ENTRY;
                    end
                end
            end
            S_ENTRY: begin
                if (cl_ev || sp_ev) begin
                    pushEv(EV_CLR, 0);
                    m_digits = 0;
                    m_mode = S_IDLE;
                end else if (st_ev) begin
                    if (door_closed && !timer_zero) begin
                        m_mode = S_COOK;
                        m_cook_cycles = 0;
                        m_digits = 0;
                    end
                end else if (key_ok && m_digits < MAX_DIGITS) begin
                    pushEv(EV_LOAD, int'(key_digit));
                    m_digits++;
                end
            end
            S_COOK: begin
                if (cl_ev) begin
                    pushEv(EV_CLR, 0);
                    m_mode = S_IDLE;
                end else if (sp_ev || !door_closed) begin
                    m_mode = S_PAUSE;
                end else if (timer_zero && m_cnt == 0) begin
                    m_mode = S_DONE;
                    m_done_cycles = 0;
                end else begin
                    m_cook_cycles++;
                    if (m_cook_cycles % TICK_DIV == 0) begin
                        pushEv(EV_CNT, 0);
                        cnt_now = 1;
                    end
                end
            end
            S_PAUSE: begin
                if (cl_ev || sp_ev) begin
                    pushEv(EV_CLR, 0);
                    m_mode = S_IDLE;
                end else if (st_ev && door_closed) begin
                    m_mode = S_COOK;
                end
            end
            default: begin
                if (cl_ev || sp_ev || key_ok) m_mode = S_IDLE;
                else begin
                    m_done_cycles++;
                    if (m_done_cycles == BEEP_TICKS * TICK_DIV) m_mode = S_IDLE;
                end
            end
        endcase
        m_cnt = cnt_now;
        exp_q.push_back('{m_mode, (m_mode == S_DONE) ? 1 : 0,
                          (m_mode == S_COOK && door_closed) ? 1 : 0});
        scyc++;
        @(negedge clk);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    task automatic pressKey(input int d);
        key_valid = 1'b1;
        key_digit = 4'(d);
        applyStimulus();
        key_valid = 1'b0;
    endtask

    task automatic pressButton(input int which);
        if (which == 0) start_n = 1'b0;
        if (which == 1) stop_n = 1'b0;
        if (which == 2) clear_n = 1'b0;
        applyStimulus();
        start_n = 1'b1;
        stop_n  = 1'b1;
        clear_n = 1'b1;
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_state", int'(state), S_IDLE);
        checkOutput("rst_load_n", int'(load_n), 1);
        checkOutput("rst_load_data", int'(load_data), 0);
        checkOutput("rst_timer_clr_n", int'(timer_clr_n), 1);
        checkOutput("rst_count_en", int'(count_en), 0);
        checkOutput("rst_mag_on", int'(mag_on), 0);
        checkOutput("rst_beep", int'(beep), 0);
    endtask

    // Monitor: per-cycle level check plus strobe matching whenever the DUT pulses
    initial begin
        snap_t s;
        ev_t   e;
        int    kind;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (exp_q.size() == 0) checkOutput("exp_underflow", 1, 0);
                else begin
                    s = exp_q.pop_front();
                    checkOutput("state", int'(state), s.st);
                    checkOutput("beep", int'(beep), s.bp);
                    checkOutput("mag_on", int'(mag_on), s.mag);
                end
                while (ev_q.size() > 0 && ev_q[0].cyc < mcyc) begin
                    e = ev_q.pop_front();
                    checkOutput("missing_strobe", 0, e.kind);
                end
                kind = (!load_n ? EV_LOAD : 0) | (!timer_clr_n ? EV_CLR : 0) | (count_en ? EV_CNT : 0);
                if (kind != 0) begin
                    if (ev_q.size() == 0 || ev_q[0].cyc != mcyc) checkOutput("unexpected_strobe", kind, 0);
                    else begin
                        e = ev_q.pop_front();
                        checkOutput("strobe_kind", kind, e.kind);
                        if (e.kind == EV_LOAD) checkOutput("load_data", int'(load_data), e.data);
                    end
                end
                mcyc++;
            end
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        scyc = 0;
        mcyc = 0;
        mon_en = 1'b0;
        clrn = 1'b0;
        key_valid = 1'b0;
        key_digit = 4'd0;
        start_n = 1'b1;
        stop_n = 1'b1;
        clear_n = 1'b1;
        door_closed = 1'b1;
        timer_zero = 1'b0;
        modelReset();
        repeat (3) @(negedge clk);
        checkResetOutputs();

        clrn = 1'b1;
        mon_en = 1'b1;

        // Entry of 1,3,0 then start and steady cooking
        pressKey(1);
        idleCycles(1);
        pressKey(3);
        pressKey(0);
        pressButton(0);
        idleCycles(10);

        // Stop, pause, resume with the held prescaler phase
        pressButton(1);
        idleCycles(3);
        pressButton(0);
        idleCycles(6);

        // Door opening gates the magnetron before the FSM moves
        door_closed = 1'b0;
        #1;
        checkOutput("mag_door_gate", int'(mag_on), 0);
        checkOutput("state_before_pause", int'(state), S_COOK);
        idleCycles(2);
        pressButton(0);
        idleCycles(2);
        door_closed = 1'b1;
        pressButton(0);
        idleCycles(3);

        // Timer reaches zero: beep window then back to idle
        timer_zero = 1'b1;
        idleCycles(3);
        timer_zero = 1'b0;
        idleCycles(14);

        // Fourth digit ignored; clear beats start in the same cycle
        pressKey(1);
        pressKey(2);
        pressKey(3);
        pressKey(4);
        idleCycles(2);
        clear_n = 1'b0;
        start_n = 1'b0;
        applyStimulus();
        clear_n = 1'b1;
        start_n = 1'b1;
        idleCycles(2);

        // Out-of-range digit ignored; held buttons yield a single event
        pressKey(12);
        pressKey(5);
        start_n = 1'b0;
        idleCycles(5);
        start_n = 1'b1;
        stop_n = 1'b0;
        idleCycles(3);
        stop_n = 1'b1;
        idleCycles(2);
        pressButton(2);
        idleCycles(2);

        // Asynchronous reset in the middle of cooking
        pressKey(7);
        pressButton(0);
        idleCycles(5);
        mon_en = 1'b0;
        #3;
        clrn = 1'b0;
        #1;
        checkResetOutputs();
        @(negedge clk);
        modelReset();
        clrn = 1'b1;
        mon_en = 1'b1;

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            key_valid = ($urandom_range(0, 3) == 0);
            key_digit = 4'($urandom_range(0, 15));
            if (!start_n) start_n = $urandom_range(0, 1) == 1;
            else start_n = !($urandom_range(0, 19) == 0);
            if (!stop_n) stop_n = $urandom_range(0, 1) == 1;
            else stop_n = !($urandom_range(0, 39) == 0);
            if (!clear_n) clear_n = $urandom_range(0, 1) == 1;
            else clear_n = !($urandom_range(0, 59) == 0);
            if (door_closed) door_closed = !($urandom_range(0, 39) == 0);
            else door_closed = $urandom_range(0, 4) == 0;
            if (timer_zero) timer_zero = !($urandom_range(0, 3) == 0);
            else timer_zero = $urandom_range(0, 49) == 0;
            applyStimulus();
        end
        key_valid = 1'b0;
        start_n = 1'b1;
        stop_n = 1'b1;
        clear_n = 1'b1;
        door_closed = 1'b1;
        timer_zero = 1'b0;
        idleCycles(4);

        mon_en = 1'b0;
        checkOutput("pending_strobes", ev_q.size(), 0);
        checkOutput("pending_levels", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
